// File: rtl/picosoc_iomem_timer.sv
// iomem-mapped down-counting timer with one-shot / auto-reload modes and a level irq.
// Optional PRESCALE register (offset 0x10) is built when PICOSOC_TIMER_PRESCALE_EN is defined.
module picosoc_iomem_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic        auto_q, auto_d, irqen_q, irqen_d;
    logic [31:0] load_q, load_d, count_q, count_d;
    logic        expired_q, expired_d;
    logic        ready_d;
    logic [31:0] rdata_d;
    logic        sel, acc, wr, tick, expire;
    logic [2:0]  offs;
    logic        unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int unsigned i = 0; i < 4; i++)
            if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    assign sel         = iomem_valid && (iomem_addr[31:8] == BASE_ADDR[31:8]);
    assign acc         = sel && !iomem_ready;
    assign wr          = acc && (iomem_wstrb != '0);
    // Offsets beyond 0x1C alias to an unused slot so they read 0.
    assign offs        = (iomem_addr[7:5] == '0) ? iomem_addr[4:2] : 3'd7;
    assign unused_addr = ^iomem_addr[1:0];
    assign irq         = expired_q & irqen_q;

`ifdef PICOSOC_TIMER_PRESCALE_EN
    logic [15:0] presc_q, presc_d, pcnt_q, pcnt_d;
    assign tick = (state_q == RUN) && (pcnt_q == presc_q);
`else
    assign tick = (state_q == RUN);
`endif

    always_comb begin
        state_d   = state_q;
        auto_d    = auto_q;
        irqen_d   = irqen_q;
        load_d    = load_q;
        count_d   = count_q;
        expired_d = expired_q;
        expire    = 1'b0;
        ready_d   = acc;
        rdata_d   = '0;
`ifdef PICOSOC_TIMER_PRESCALE_EN
        presc_d   = presc_q;
        pcnt_d    = (state_q == RUN) ? (tick ? '0 : pcnt_q + 16'd1) : '0;
`endif

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else begin
                expire = 1'b1;
                if (auto_q) count_d = load_q;
                else        state_d = IDLE;
            end
        end

        if (acc) begin
            case (offs)
                3'd0:    rdata_d = {29'b0, irqen_q, auto_q, state_q == RUN};
                3'd1:    rdata_d = load_q;
                3'd2:    rdata_d = count_q;
                3'd3:    rdata_d = {31'b0, expired_q};
`ifdef PICOSOC_TIMER_PRESCALE_EN
                3'd4:    rdata_d = {16'b0, presc_q};
`endif
                default: rdata_d = '0;
            endcase
        end

        // Bus writes land after the timer update so they win on COUNT and EN.
        if (wr) begin
            case (offs)
                3'd0: if (iomem_wstrb[0]) begin
                    state_d = iomem_wdata[0] ? RUN : IDLE;
                    auto_d  = iomem_wdata[1];
                    irqen_d = iomem_wdata[2];
                end
                3'd1: load_d  = merge(load_q, iomem_wdata, iomem_wstrb);
                3'd2: count_d = merge(count_d, iomem_wdata, iomem_wstrb);
                3'd3: if (iomem_wstrb[0] && iomem_wdata[0]) expired_d = 1'b0;
`ifdef PICOSOC_TIMER_PRESCALE_EN
                3'd4: begin
                    presc_d = merge({16'b0, presc_q}, iomem_wdata, iomem_wstrb & 4'b0011) >> 0;
                    pcnt_d  = '0;
                end
`endif
                default: ;
            endcase
        end

        if (expire) expired_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            auto_q      <= 1'b0;
            irqen_q     <= 1'b0;
            load_q      <= '0;
            count_q     <= '0;
            expired_q   <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= '0;
`ifdef PICOSOC_TIMER_PRESCALE_EN
            presc_q     <= '0;
            pcnt_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            auto_q      <= auto_d;
            irqen_q     <= irqen_d;
            load_q      <= load_d;
            count_q     <= count_d;
            expired_q   <= expired_d;
            iomem_ready <= ready_d;
            iomem_rdata <= rdata_d;
`ifdef PICOSOC_TIMER_PRESCALE_EN
            presc_q     <= presc_d;
            pcnt_q      <= pcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_picosoc_iomem_timer.sv
// Directed self-checking bench for picosoc_iomem_timer: register table plus timed sequences.
// Prescaler checks are built only with PICOSOC_TIMER_PRESCALE_EN.
module tb_picosoc_iomem_timer;

    localparam logic [31:0] A_CTRL   = 32'h0300_0000;
    localparam logic [31:0] A_LOAD   = 32'h0300_0004;
    localparam logic [31:0] A_COUNT  = 32'h0300_0008;
    localparam logic [31:0] A_STATUS = 32'h0300_000C;
    localparam logic [31:0] A_PRESC  = 32'h0300_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iomem_valid = 1'b0;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb = '0;
    logic [31:0] iomem_addr = '0;
    logic [31:0] iomem_wdata = '0;
    logic [31:0] iomem_rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    picosoc_iomem_timer #(.BASE_ADDR(32'h0300_0000)) dut (
        .clk(clk), .reset(reset), .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata), .irq(irq)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic [31:0] exp;
    } tvec_t;

    vec_t  vecs[$];
    tvec_t rel[$];
    tvec_t pre[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Starts 1 time unit after a rising edge; ends 1 time unit after the edge following the ack.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r);
        int n;
        iomem_valid = 1'b1; iomem_addr = a; iomem_wdata = d; iomem_wstrb = s;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!iomem_ready && n < 8);
        chk("ack_latency", n, 1);
        r = iomem_rdata;
        iomem_valid = 1'b0; iomem_wstrb = '0;
        @(posedge clk); #1;
        chk("ready_drop", {31'b0, iomem_ready}, 32'd0);
        chk("rdata_idle", iomem_rdata, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        xfer(a, d, s, r);
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(a, 32'hA5A5_A5A5, 4'b0000, r);
        chk(nm, r, exp);
    endtask

    task automatic wait_cyc(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic no_ack(input string nm, input logic [31:0] a);
        logic seen;
        seen = 1'b0;
        iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = 4'hF; iomem_wdata = '1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) seen = 1'b1;
        end
        iomem_valid = 1'b0; iomem_wstrb = '0;
        chk(nm, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        logic seen;

        vecs.push_back('{A_CTRL,   32'h0,         4'h0, 32'h0});
        vecs.push_back('{A_LOAD,   32'h0,         4'h0, 32'h0});
        vecs.push_back('{A_COUNT,  32'h0,         4'h0, 32'h0});
        vecs.push_back('{A_STATUS, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{A_LOAD,   32'hDEAD_BEEF, 4'hF, 32'h0});
        vecs.push_back('{A_LOAD,   32'h0,         4'h0, 32'hDEAD_BEEF});
        vecs.push_back('{A_LOAD,   32'h0,         4'hF, 32'h0});
        vecs.push_back('{A_LOAD,   32'h1122_3344, 4'h1, 32'h0});
        vecs.push_back('{A_LOAD,   32'h0,         4'h0, 32'h0000_0044});
        vecs.push_back('{A_LOAD,   32'hAABB_CCDD, 4'hC, 32'h0});
        vecs.push_back('{A_LOAD,   32'h0,         4'h0, 32'hAABB_0044});
        vecs.push_back('{A_CTRL,   32'h6,         4'hF, 32'h0});
        vecs.push_back('{A_CTRL,   32'hFFFF_FFFF, 4'h2, 32'h0});
        vecs.push_back('{A_CTRL,   32'h0,         4'h0, 32'h6});
        vecs.push_back('{A_CTRL,   32'hFFFF_FFF8, 4'hF, 32'h0});
        vecs.push_back('{A_CTRL,   32'h0,         4'h0, 32'h0});
        vecs.push_back('{32'h0300_0014, 32'hFFFF_FFFF, 4'hF, 32'h0});
        vecs.push_back('{32'h0300_0014, 32'h0,    4'h0, 32'h0});
        vecs.push_back('{32'h0300_001C, 32'h0,    4'h0, 32'h0});
        vecs.push_back('{A_COUNT,  32'h1234_5678, 4'hF, 32'h0});
        vecs.push_back('{A_LOAD,   32'h55,        4'hF, 32'h0});
        vecs.push_back('{A_COUNT,  32'h0,         4'h0, 32'h1234_5678});
        vecs.push_back('{A_STATUS, 32'h1,         4'hF, 32'h0});
        vecs.push_back('{A_STATUS, 32'h0,         4'h0, 32'h0});
        vecs.push_back('{A_PRESC,  32'hFFFF_FFFF, 4'hF, 32'h0});
`ifdef PICOSOC_TIMER_PRESCALE_EN
        vecs.push_back('{A_PRESC,  32'h0,         4'h0, 32'h0000_FFFF});
        vecs.push_back('{A_PRESC,  32'h0,         4'hF, 32'h0});
`else
        vecs.push_back('{A_PRESC,  32'h0,         4'h0, 32'h0});
`endif

        // Waits k cycles after CTRL=3 (ack edge E0); the read returns COUNT/STATUS after edge E(1+k).
        rel.push_back('{0, A_COUNT, 32'd2});
        rel.push_back('{1, A_COUNT, 32'd1});
        rel.push_back('{2, A_COUNT, 32'd0});
        rel.push_back('{3, A_COUNT, 32'd3});
        rel.push_back('{4, A_COUNT, 32'd2});
        rel.push_back('{6, A_COUNT, 32'd0});
        rel.push_back('{7, A_COUNT, 32'd3});
        rel.push_back('{2, A_STATUS, 32'd0});
        rel.push_back('{3, A_STATUS, 32'd1});

        pre.push_back('{1, A_COUNT, 32'd10});
        pre.push_back('{2, A_COUNT, 32'd9});
        pre.push_back('{4, A_COUNT, 32'd9});
        pre.push_back('{5, A_COUNT, 32'd8});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", {31'b0, iomem_ready}, 32'd0);
        chk("reset_rdata", iomem_rdata, 32'd0);
        chk("reset_irq", {31'b0, irq}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            logic [31:0] r;
            xfer(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, r);
            if (vecs[i].wstrb == '0)
                chk($sformatf("vec[%0d]", i), r, vecs[i].exp);
        end

        no_ack("unselected_hi", 32'h0400_0008);
        no_ack("unselected_b8", 32'h0300_0108);
        wait_cyc(1);

        // One-shot: COUNT=5, enable with IRQ_EN; expiry on the 6th tick after the enable edge.
        wr(A_COUNT, 32'd5, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        wait_cyc(4);
        chk("oneshot_irq_early", {31'b0, irq}, 32'd0);
        wait_cyc(1);
        chk("oneshot_irq", {31'b0, irq}, 32'd1);
        rd_chk("oneshot_ctrl", A_CTRL, 32'h4);
        rd_chk("oneshot_count", A_COUNT, 32'd0);
        rd_chk("oneshot_status", A_STATUS, 32'd1);
        wr(A_STATUS, 32'h1, 4'hF);
        chk("w1c_irq", {31'b0, irq}, 32'd0);

        // W1C lands on the expiry edge: expiry wins.
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_COUNT, 32'd1, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_STATUS, 32'h1, 4'hF);
        rd_chk("w1c_vs_expiry", A_STATUS, 32'd1);
        rd_chk("w1c_vs_expiry_en", A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1, 4'hF);
        rd_chk("w1c_clear", A_STATUS, 32'd0);

        // COUNT write on the one-shot expiry edge beats the hold-at-zero.
        wr(A_COUNT, 32'd1, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_COUNT, 32'd100, 4'hF);
        rd_chk("cntwr_vs_expiry", A_COUNT, 32'd100);
        rd_chk("cntwr_vs_expiry_en", A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1, 4'hF);

        // COUNT write on a decrement edge, then two more ticks before the read, stop on a tick edge.
        wr(A_COUNT, 32'd1000, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_COUNT, 32'd100, 4'hF);
        rd_chk("cntwr_vs_decr", A_COUNT, 32'd99);
        wr(A_CTRL, 32'h0, 4'hF);
        rd_chk("count_after_stop", A_COUNT, 32'd96);

        foreach (rel[i]) begin
            wr(A_CTRL, 32'h0, 4'hF);
            wr(A_STATUS, 32'h1, 4'hF);
            wr(A_LOAD, 32'd3, 4'hF);
            wr(A_COUNT, 32'd3, 4'hF);
            wr(A_CTRL, 32'h3, 4'hF);
            wait_cyc(rel[i].k);
            rd_chk($sformatf("reload[%0d]", i), rel[i].addr, rel[i].exp);
        end
        wr(A_CTRL, 32'h0, 4'hF);
        wr(A_STATUS, 32'h1, 4'hF);

`ifdef PICOSOC_TIMER_PRESCALE_EN
        foreach (pre[i]) begin
            wr(A_CTRL, 32'h0, 4'hF);
            wr(A_PRESC, 32'd2, 4'hF);
            wr(A_COUNT, 32'd10, 4'hF);
            wr(A_CTRL, 32'h1, 4'hF);
            wait_cyc(pre[i].k);
            rd_chk($sformatf("prescale[%0d]", i), pre[i].addr, pre[i].exp);
        end
        wr(A_CTRL, 32'h0, 4'hF);
`endif

        // Reset mid-run with irq high and a read acknowledged this cycle.
        wr(A_COUNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        wr(A_LOAD, 32'h1234, 4'hF);
        wr(A_COUNT, 32'd50, 4'hF);
        wr(A_CTRL, 32'h7, 4'hF);
        chk("prereset_irq", {31'b0, irq}, 32'd1);
        iomem_valid = 1'b1; iomem_addr = A_COUNT; iomem_wstrb = '0;
        @(posedge clk); #1;
        chk("prereset_ready", {31'b0, iomem_ready}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_ready", {31'b0, iomem_ready}, 32'd0);
        chk("async_rdata", iomem_rdata, 32'd0);
        chk("async_irq", {31'b0, irq}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        iomem_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (iomem_ready) seen = 1'b1;
        end
        chk("post_reset_no_ready", {31'b0, seen}, 32'd0);
        rd_chk("post_reset_ctrl", A_CTRL, 32'h0);
        rd_chk("post_reset_load", A_LOAD, 32'h0);
        rd_chk("post_reset_count", A_COUNT, 32'h0);
        rd_chk("post_reset_status", A_STATUS, 32'h0);
        chk("post_reset_irq", {31'b0, irq}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/picosoc_iomem_timer.md
PICOSOC_IOMEM_TIMER -- requirements
Module: picosoc_iomem_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0300_0000, iomem base address; only bits [31:8] are decoded.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port iomem_valid, input, 1, initiator request valid.
REQ-005 SHALL have port iomem_ready, output, 1, responder transfer done.
REQ-006 SHALL have port iomem_wstrb, input, 4, byte write strobes; 0 means read.
REQ-007 SHALL have port iomem_addr, input, 32, byte address.
REQ-008 SHALL have port iomem_wdata, input, 32, write data.
REQ-009 SHALL have port iomem_rdata, output, 32, read data.
REQ-010 SHALL have port irq, output, 1, level interrupt for a CPU irq input (irq_5).

Function
REQ-011 SHALL treat the block as selected when iomem_valid=1 and iomem_addr[31:8]=BASE_ADDR[31:8]; register offset is iomem_addr[4:2].
REQ-012 SHALL register iomem_ready: high exactly one cycle, in the cycle after select while iomem_ready was 0; never high when not selected.
REQ-013 SHALL drive iomem_rdata in the same cycle as iomem_ready, and 0 in every other cycle.
REQ-014 SHALL apply writes in the ready cycle's preceding edge, per byte lane of iomem_wstrb; reads have no side effects.
REQ-015 SHALL implement: 0x00 CTRL [0]=EN [1]=AUTO_RELOAD [2]=IRQ_EN; 0x04 LOAD 32b; 0x08 COUNT 32b read/write; 0x0C STATUS [0]=EXPIRED, write-1-to-clear; unused bits and offsets 0x14-0x1C read 0, writes ignored, still acknowledged.
REQ-016 SHALL implement states IDLE (EN=0) and RUN (EN=1); setting EN moves IDLE->RUN, clearing EN or non-reload expiry moves RUN->IDLE.
REQ-017 SHALL, in RUN on each tick, decrement COUNT by 1 when COUNT!=0.
REQ-018 SHALL, in RUN on a tick with COUNT=0, set EXPIRED; if AUTO_RELOAD then COUNT<=LOAD and stay in RUN, else clear EN and hold COUNT=0.
REQ-019 SHALL not alter COUNT on a LOAD write.
REQ-020 SHALL give a bus write to COUNT priority over a same-cycle decrement or reload.
REQ-021 SHALL give a same-cycle expiry priority over a W1C of EXPIRED (bit stays 1).
REQ-022 SHALL drive irq = EXPIRED & IRQ_EN combinationally from registers.
REQ-023 SHALL treat COUNT=0 with EN set as expiring on the first tick.

Reset
REQ-024 SHALL on reset assertion immediately clear CTRL, LOAD, COUNT, STATUS, prescaler state, iomem_ready=0, iomem_rdata=0, irq=0, state=IDLE.
REQ-025 SHALL abandon a transaction in progress on reset; no ready pulse is issued for it after release.

Configuration
REQ-026 SHALL, with PICOSOC_TIMER_PRESCALE_EN defined, add 0x10 PRESCALE [15:0] (reset 0); tick occurs every PRESCALE+1 cycles; prescale counter clears on EN 0->1 and on any PRESCALE write.
REQ-027 SHALL, without PICOSOC_TIMER_PRESCALE_EN, tick every clk cycle in RUN; offset 0x10 reads 0, writes ignored, acknowledged.

Verification
REQ-028 SHALL verify handshake: read 0x0300_0004 after writing LOAD=32'hDEAD_BEEF -> ready one cycle after valid, rdata=32'hDEAD_BEEF, ready low next cycle.
REQ-029 SHALL verify one-shot: COUNT=5, CTRL=32'h5 -> EXPIRED and irq rise 6 ticks after EN, EN reads 0, COUNT reads 0.
REQ-030 SHALL verify reload: LOAD=3, COUNT=3, CTRL=32'h3 -> EXPIRED set every 4 ticks, COUNT sequence 3,2,1,0,3.
REQ-031 SHALL verify priority: W1C STATUS on same edge as expiry -> EXPIRED remains 1; COUNT write 100 on a tick edge -> COUNT reads 100.
REQ-032 SHALL verify byte strobes: CTRL write wdata=32'hFFFF_FFFF wstrb=4'b0010 -> CTRL unchanged; LOAD write 32'h1122_3344 wstrb=4'b0001 over 0 -> 32'h0000_0044.
REQ-033 SHALL verify reset mid-run: assert reset with COUNT=50 in RUN -> all registers 0, irq 0, no ready pulse after release; with macro, PRESCALE=2 -> tick every 3 cycles.
